// File: rtl/rf_scoreboard_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Pure declarations: no logic, no latency, no flow control.
package rf_scoreboard_pkg;

  localparam int RF_DATA_W_DEFAULT = 32;
  localparam int RF_ADDR_W_DEFAULT = 5;

  localparam int   RF_ADDR_ZERO     = 0;
  localparam logic RF_WRITE_ENABLED = 1'b1;

  // Trace format: register, old value, new value.
  localparam string RF_TRACE_FMT = "rf: r%0d %h -> %h";

  // A port commits only when enabled, out of reset, and not aimed at r0.
  function automatic logic rf_port_writes(input logic en, input logic rst, input logic addr_is_zero);
    return (en == RF_WRITE_ENABLED) && !rst && !addr_is_zero;
  endfunction

endpackage

// File: rtl/rf_scoreboard_busy.sv
// Per-register busy bits with flush/write-clear/reserve-set priority plus registered popcount.
// One-cycle update on the clock edge; no backpressure, accepts every cycle.
module rf_scoreboard_busy
  import rf_scoreboard_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W_DEFAULT
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_we0,
  input  logic [ADDR_W-1:0]      i_wa0,
  input  logic                   i_we1,
  input  logic [ADDR_W-1:0]      i_wa1,
  input  logic                   i_reserve,
  input  logic [ADDR_W-1:0]      i_reserve_addr,
  input  logic                   i_flush,
  output logic [2**ADDR_W-1:0]   o_busy,
  output logic [ADDR_W:0]        o_busy_count
);

  localparam int NREGS = 2**ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [NREGS-1:0] r_busy;
  logic [CNT_W-1:0] r_count;
  logic [NREGS-1:0] w_next;
  logic [CNT_W-1:0] w_count;

  // Reserve is applied last so a newly issued producer beats a retiring one.
  always_comb begin
    w_next = i_flush ? '0 : r_busy;
    if (i_we0) w_next[i_wa0] = 1'b0;
    if (i_we1) w_next[i_wa1] = 1'b0;
    if (i_reserve && (i_reserve_addr != ADDR_W'(RF_ADDR_ZERO))) w_next[i_reserve_addr] = 1'b1;
    w_next[0] = 1'b0;
    w_count = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_count = w_count + CNT_W'(w_next[i]);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      r_busy  <= w_next;
      r_count <= w_count;
    end
  end

  assign o_busy       = r_busy;
  assign o_busy_count = r_count;

endmodule

// File: rtl/rf_scoreboard.sv
// Two-write, two-read register file with optional write-to-read bypass and busy scoreboard.
// Reads are combinational (zero latency), writes land on the edge; no backpressure.
module rf_scoreboard
  import rf_scoreboard_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W_DEFAULT,
  parameter int ADDR_W = RF_ADDR_W_DEFAULT,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  output logic [DATA_W-1:0] read_result1,
  output logic [DATA_W-1:0] read_result2,
  output logic              read_busy1,
  output logic              read_busy2,
  input  logic              write_enable0,
  input  logic [ADDR_W-1:0] write_addr0,
  input  logic [DATA_W-1:0] write_data0,
  input  logic              write_enable1,
  input  logic [ADDR_W-1:0] write_addr1,
  input  logic [DATA_W-1:0] write_data1,
  input  logic              reserve_enable,
  input  logic [ADDR_W-1:0] reserve_addr,
  input  logic              flush,
  output logic [ADDR_W:0]   busy_count
);

  localparam int NREGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ADDR_ZERO);

  logic [DATA_W-1:0]          r_mem [NREGS];
  logic [NREGS-1:0]           w_busy;
  logic                       w_we0;
  logic                       w_we1;
  logic                       w_we1_store;
  logic [1:0][ADDR_W-1:0]     w_ra;
  logic [1:0][DATA_W-1:0]     w_rd;
  logic [1:0]                 w_rb;

  assign w_we0       = rf_port_writes(write_enable0, reset, write_addr0 == ZERO_ADDR);
  assign w_we1       = rf_port_writes(write_enable1, reset, write_addr1 == ZERO_ADDR);
  // Port 1 loses a same-address collision but still counts as a write for bypass/busy.
  assign w_we1_store = w_we1 && !(w_we0 && (write_addr1 == write_addr0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else begin
      if (w_we0)       r_mem[write_addr0] <= write_data0;
      if (w_we1_store) r_mem[write_addr1] <= write_data1;
    end
  end

  assign w_ra[0] = read_addr1;
  assign w_ra[1] = read_addr2;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic w_hit0;
    logic w_hit1;
    assign w_hit0  = (BYPASS != 0) && w_we0 && (write_addr0 == w_ra[p]);
    assign w_hit1  = (BYPASS != 0) && w_we1 && (write_addr1 == w_ra[p]);
    assign w_rd[p] = (w_ra[p] == ZERO_ADDR) ? '0 :
                     w_hit0                 ? write_data0 :
                     w_hit1                 ? write_data1 :
                                              r_mem[w_ra[p]];
    assign w_rb[p] = w_busy[w_ra[p]] & ~(w_hit0 | w_hit1);
  end

  assign read_result1 = w_rd[0];
  assign read_result2 = w_rd[1];
  assign read_busy1   = w_rb[0];
  assign read_busy2   = w_rb[1];

  rf_scoreboard_busy #(
    .ADDR_W (ADDR_W)
  ) u_busy (
    .i_clk          (clk),
    .i_rst          (reset),
    .i_we0          (w_we0),
    .i_wa0          (write_addr0),
    .i_we1          (w_we1),
    .i_wa1          (write_addr1),
    .i_reserve      (reserve_enable),
    .i_reserve_addr (reserve_addr),
    .i_flush        (flush),
    .o_busy         (w_busy),
    .o_busy_count   (busy_count)
  );

endmodule

// File: tb/tb_rf_scoreboard.sv
// Scoreboard bench for rf_scoreboard: bypassed and non-bypassed instances share stimulus.
module tb_rf_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;

  localparam int K_RD1 = 0, K_RD2 = 1, K_BUSY1 = 2, K_BUSY2 = 3, K_CNT = 4;
  localparam int K_NB_RD1 = 5, K_NB_RD2 = 6, K_NB_BUSY1 = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] read_addr1, read_addr2;
  logic [DW-1:0] read_result1, read_result2, nb_result1, nb_result2;
  logic          read_busy1, read_busy2, nb_busy1, nb_busy2;
  logic          write_enable0, write_enable1;
  logic [AW-1:0] write_addr0, write_addr1;
  logic [DW-1:0] write_data0, write_data1;
  logic          reserve_enable;
  logic [AW-1:0] reserve_addr;
  logic          flush;
  logic [AW:0]   busy_count, nb_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  rf_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1)) u_dut (
    .clk(clk), .reset(reset),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_result1(read_result1), .read_result2(read_result2),
    .read_busy1(read_busy1), .read_busy2(read_busy2),
    .write_enable0(write_enable0), .write_addr0(write_addr0), .write_data0(write_data0),
    .write_enable1(write_enable1), .write_addr1(write_addr1), .write_data1(write_data1),
    .reserve_enable(reserve_enable), .reserve_addr(reserve_addr),
    .flush(flush), .busy_count(busy_count)
  );

  rf_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0)) u_dut_nb (
    .clk(clk), .reset(reset),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_result1(nb_result1), .read_result2(nb_result2),
    .read_busy1(nb_busy1), .read_busy2(nb_busy2),
    .write_enable0(write_enable0), .write_addr0(write_addr0), .write_data0(write_data0),
    .write_enable1(write_enable1), .write_addr1(write_addr1), .write_data1(write_data1),
    .reserve_enable(reserve_enable), .reserve_addr(reserve_addr),
    .flush(flush), .busy_count(nb_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int kind, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.kind = kind; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_RD1:      obs = read_result1;
        K_RD2:      obs = read_result2;
        K_BUSY1:    obs = {31'd0, read_busy1};
        K_BUSY2:    obs = {31'd0, read_busy2};
        K_CNT:      obs = {26'd0, busy_count};
        K_NB_RD1:   obs = nb_result1;
        K_NB_RD2:   obs = nb_result2;
        K_NB_BUSY1: obs = {31'd0, nb_busy1};
        default:    obs = 'x;
      endcase
      chk(e.tag, obs, e.exp);
    end
  endtask

  task automatic clr_in();
    read_addr1 = '0; read_addr2 = '0;
    write_enable0 = 1'b0; write_addr0 = '0; write_data0 = '0;
    write_enable1 = 1'b0; write_addr1 = '0; write_data1 = '0;
    reserve_enable = 1'b0; reserve_addr = '0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr_in();
  endtask

  task automatic reserve(input int r);
    step();
    reserve_enable = 1'b1; reserve_addr = AW'(r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_in();
    reset = 1'b1;
    #12;
    read_addr1 = 5;
    #1;
    push("rst_rd1", K_RD1, 0); push("rst_cnt", K_CNT, 0); drain();
    @(negedge clk) reset = 1'b0;

    // Preload r5, reserve r20, then async reset mid-cycle
    step();
    write_enable0 = 1'b1; write_addr0 = 5; write_data0 = 32'h1234_5678;
    reserve_enable = 1'b1; reserve_addr = 20;
    step();
    read_addr1 = 5; read_addr2 = 20;
    #1;
    push("w0_r5", K_RD1, 32'h1234_5678); push("busy_r20", K_BUSY2, 1); push("cnt_1", K_CNT, 1);
    drain();
    #1 reset = 1'b1;
    #1;
    push("arst_rd1", K_RD1, 0); push("arst_busy2", K_BUSY2, 0); push("arst_cnt", K_CNT, 0);
    drain();
    @(negedge clk) reset = 1'b0;

    // Write to r0 is discarded and never bypassed
    step();
    write_enable0 = 1'b1; write_addr0 = 0; write_data0 = 32'hFFFF_FFFF;
    read_addr1 = 0;
    #1 push("r0_byp", K_RD1, 0); drain();
    step();
    read_addr1 = 0;
    #1 push("r0_rd", K_RD1, 0); drain();

    // Same-address collision: port 0 wins
    step();
    write_enable0 = 1'b1; write_addr0 = 7; write_data0 = 32'hA;
    write_enable1 = 1'b1; write_addr1 = 7; write_data1 = 32'hB;
    read_addr1 = 7;
    #1 push("coll_byp", K_RD1, 32'hA); push("coll_nb_old", K_NB_RD1, 0); drain();
    step();
    read_addr1 = 7;
    #1 push("coll_r7", K_RD1, 32'hA); push("coll_nb_r7", K_NB_RD1, 32'hA); drain();

    // Distinct addresses both stored
    step();
    write_enable0 = 1'b1; write_addr0 = 3; write_data0 = 32'd1;
    write_enable1 = 1'b1; write_addr1 = 4; write_data1 = 32'd2;
    step();
    read_addr1 = 3; read_addr2 = 4;
    #1 push("dual_r3", K_RD1, 1); push("dual_r4", K_RD2, 2); drain();

    // Port 1 bypass vs no bypass
    step();
    write_enable1 = 1'b1; write_addr1 = 9; write_data1 = 32'hDEAD_BEEF;
    read_addr2 = 9;
    #1 push("byp_r9", K_RD2, 32'hDEAD_BEEF); push("nb_r9_old", K_NB_RD2, 0); drain();
    step();
    read_addr2 = 9;
    #1 push("r9_stored", K_RD2, 32'hDEAD_BEEF); push("nb_r9", K_NB_RD2, 32'hDEAD_BEEF); drain();

    // Reserve r10, complete via port 1
    reserve(10);
    read_addr1 = 10;
    #1 push("rsv_same_cyc", K_BUSY1, 0); push("rsv_cnt_pre", K_CNT, 0); drain();
    step();
    read_addr1 = 10;
    #1 push("rsv_busy", K_BUSY1, 1); push("rsv_cnt", K_CNT, 1); push("rsv_nb_busy", K_NB_BUSY1, 1); drain();
    write_enable1 = 1'b1; write_addr1 = 10; write_data1 = 32'h55;
    #1;
    push("wb_busy", K_BUSY1, 0); push("wb_rd", K_RD1, 32'h55);
    push("wb_nb_busy", K_NB_BUSY1, 1); push("wb_nb_rd", K_NB_RD1, 0); push("wb_cnt", K_CNT, 1);
    drain();
    step();
    read_addr1 = 10;
    #1 push("wb_cnt_after", K_CNT, 0); push("wb_busy_after", K_BUSY1, 0); drain();

    // Several reserves, then flush + reserve
    reserve(2); reserve(3); reserve(4);
    step();
    #1 push("cnt_3", K_CNT, 3); drain();
    flush = 1'b1; reserve_enable = 1'b1; reserve_addr = 6;
    step();
    read_addr1 = 6; read_addr2 = 2;
    #1 push("flush_r6", K_BUSY1, 1); push("flush_r2", K_BUSY2, 0); push("flush_cnt", K_CNT, 1); drain();

    // Reserve beats same-cycle write; reserve of r0 ignored
    write_enable0 = 1'b1; write_addr0 = 12; write_data0 = 32'h99;
    reserve_enable = 1'b1; reserve_addr = 12;
    read_addr1 = 12;
    #1 push("rw_pre_busy", K_BUSY1, 0); push("rw_byp", K_RD1, 32'h99); drain();
    step();
    read_addr1 = 12;
    #1 push("rw_busy", K_BUSY1, 1); push("rw_rd", K_RD1, 32'h99); push("rw_cnt", K_CNT, 2); drain();
    reserve(0);
    step();
    read_addr1 = 0;
    #1 push("rsv0_busy", K_BUSY1, 0); push("rsv0_cnt", K_CNT, 2); drain();
    flush = 1'b1;
    step();
    #1 push("flush_cnt0", K_CNT, 0); drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
- Parametrised successor to the single-write register file: general-purpose register array with two write ports, two bypassed read ports and a per-register busy scoreboard.
- Sits in the datapath decode stage. Read results feed operand muxes; busy flags feed the hazard/stall unit.
- Write port 0 is the early (ALU) writeback. Write port 1 is the late (memory/multiply) writeback.
- Register 0 reads zero and can never be written or marked busy.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; register count NREGS = 2**ADDR_W.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see array contents only.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears the array and the scoreboard.
- read_addr1  input  ADDR_W  read port 1 address.
- read_addr2  input  ADDR_W  read port 2 address.
- read_result1  output  DATA_W  read port 1 data.
- read_result2  output  DATA_W  read port 2 data.
- read_busy1  output  1  register at read_addr1 has a pending producer.
- read_busy2  output  1  register at read_addr2 has a pending producer.
- write_enable0  input  1  write port 0 enable.
- write_addr0  input  ADDR_W  write port 0 address.
- write_data0  input  DATA_W  write port 0 data.
- write_enable1  input  1  write port 1 enable.
- write_addr1  input  ADDR_W  write port 1 address.
- write_data1  input  DATA_W  write port 1 data.
- reserve_enable  input  1  mark a destination register busy.
- reserve_addr  input  ADDR_W  register to mark busy.
- flush  input  1  synchronous clear of all busy bits.
- busy_count  output  ADDR_W+1  number of busy registers.

Behaviour:
- Reset (async, active-high):
  - All registers go to 0, all busy bits to 0, busy_count to 0, immediately and independent of clk.
  - Writes, reserves and flush are ignored while reset is high.
- Writes:
  - Take effect on the rising edge of clk when the port is enabled and its address is not 0.
  - A write to address 0 is discarded.
  - Both ports enabled with the same address: port 0 data is stored; port 1 is dropped.
  - Different addresses: both are stored in the same cycle.
- Reads: combinational, zero latency.
  - Address 0 returns 0.
  - With BYPASS=1, if a write port targets the read address this cycle, the write data is returned, with the same priority (port 0 over port 1).
  - Otherwise the stored value is returned.
- Scoreboard: one busy bit per register; bit 0 is tied to 0. Next-state order for each bit, applied at the clock edge:
  1. flush clears all bits; a reserve in the same cycle still applies afterwards.
  2. A write (either port) to the address clears its bit.
  3. reserve_enable with reserve_addr != 0 sets its bit. Reserve wins over a same-cycle write to the same address, because a new producer has been issued.
  - Net result: flush + reserve(r) in the same cycle leaves only r busy.
- read_busy:
  - read_busyN = busy[addr] AND NOT (BYPASS AND a same-cycle write to addr).
  - A register being written this cycle reads as not busy with the bypassed data.
  - A same-cycle reserve does not affect read_busy until the next cycle.
- busy_count: registered population count of the busy bits, updated on the same edge as the bits. Range 0..NREGS-1.
- Over-reserve: reserving an already-busy register keeps it busy. Count tracking is not required; one write clears it.
- Out-of-order completion: port 1 may clear a bit that port 0 also targets later. The hazard unit guarantees a single outstanding producer per register; the block does not check this.
- Debug: per-write trace display via the standard debug macros, showing address, old value and new value. The macros are controlled by the debug include.

Decomposition:
- Shared package/header (rf.h successor):
  - RF_ADDR_ZERO, RF_WRITE_ENABLED.
  - Default DATA_W and ADDR_W.
  - Output trace format string.
- Sub-module rf_scoreboard_busy: busy bit vector, next-state priority logic and popcount register.
- The data array and read muxing stay in the top module.

Test Plan:
- Assert reset with registers preloaded → all reads 0, read_busy 0, busy_count 0 within the same cycle, without a clock edge.
- Write port 0: r5 = 0x1234_5678. Next cycle read_addr1=5 → 0x1234_5678. Write r0 = 0xFFFF_FFFF → read r0 = 0.
- Same cycle: port 0 writes r7 = 0xA, port 1 writes r7 = 0xB → read r7 = 0xA. Port 0 r3 = 1 with port 1 r4 = 2 → both stored.
- BYPASS=1: port 1 writes r9 = 0xDEAD_BEEF while read_addr2=9 → read_result2 = 0xDEAD_BEEF in the same cycle. BYPASS=0 → old value 0.
- Reserve r10 → next cycle read_busy1 = 1, busy_count = 1. Port 1 write r10 = 0x55 → read_busy1 = 0 and read = 0x55 in the write cycle; busy_count = 0 after the edge.
- Reserve r2, r3, r4 → busy_count = 3. Flush + reserve r6 in one cycle → only r6 busy, busy_count = 1. Reserve r12 while writing r12 in the same cycle → r12 busy after the edge.
